// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//   APB initiator that turns a single-cycle request strobe from the core's data
//   bus into one APB SETUP/ACCESS transfer. It decodes the address to one PSEL,
//   waits for that slave's PREADY, and returns read data with a one-cycle
//   completion pulse. The error flag marks unmapped addresses and slaves that
//   never raise PREADY.
//
//   Core side
//     PCLK, PRESET        clock (rising edge), async active-high reset
//     transfer            request strobe; write/addr/wdata are sampled with it
//     write, addr, wdata  request direction, byte address, write data
//     rdata               read data, valid while ready=1, held afterwards
//     ready, err          one-cycle completion pulse and its error qualifier
//     busy                a transfer is in flight (state != IDLE)
//   APB side
//     PADDR, PWRITE, PWDATA, PENABLE, PSEL[NUM_SLV-1:0]
//     PRDATA_i[32*NUM_SLV-1:0]  slave i read data at [32*i +: 32]
//     PREADY_i[NUM_SLV-1:0]     slave i ready at bit i
//
//   Handshake: a request is accepted only when transfer=1 is sampled while
//   the FSM is IDLE (busy=0). Each accepted request produces exactly one
//   ready=1 cycle; err is meaningful only in that cycle and is 0 otherwise.
//   transfer sampled while busy is dropped, never queued. A new request may
//   be presented during the ready cycle, since the FSM is already IDLE then.
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  transfer,
    input  logic                  write,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  err,
    output logic                  busy,
    output logic [31:0]           PADDR,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [31:0]           PWDATA,
    output logic [NUM_SLV-1:0]    PSEL,
    input  logic [32*NUM_SLV-1:0] PRDATA_i,
    input  logic [NUM_SLV-1:0]    PREADY_i
);

    // The counter only has to reach TIMEOUT-1: the abort decision is taken on
    // the ACCESS cycle in which the count would otherwise hit TIMEOUT.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [31:0]          paddr_q,   paddr_d;
    logic                 pwrite_q,  pwrite_d;
    logic [31:0]          pwdata_q,  pwdata_d;
    logic                 penable_q, penable_d;
    logic [NUM_SLV-1:0]   psel_q,    psel_d;
    logic [31:0]          rdata_q,   rdata_d;
    logic                 ready_q,   ready_d;
    logic                 err_q,     err_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;

    // Address decode: slave i owns 0x1000_i000 .. 0x1000_iFFF.
    logic [NUM_SLV-1:0]   dec_sel;
    logic                 hit;

    always_comb begin
        dec_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            dec_sel[i] = (addr[31:16] == 16'h1000) && (addr[15:12] == 4'(i));
        end
    end

    assign hit = |dec_sel;

    // Return path is steered by the registered one-hot PSEL, so unselected
    // slaves can never influence ready/rdata.
    logic                 sel_ready;
    logic [31:0]          sel_rdata;

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) begin
                sel_ready = PREADY_i[i];
                sel_rdata = PRDATA_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        penable_d = penable_q;
        psel_d    = psel_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (transfer) begin
                    if (hit) begin
                        paddr_d   = addr;
                        pwrite_d  = write;
                        pwdata_d  = wdata;
                        psel_d    = dec_sel;
                        penable_d = 1'b0;
                        state_d   = S_SETUP;
                    end else begin
                        // Unmapped: complete with error without touching APB.
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end

            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end

            S_ACCESS: begin
                // PREADY is checked before the limit so a slave answering on
                // the last permitted cycle still completes cleanly.
                if (sel_ready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    if (!pwrite_q) begin
                        rdata_d = sel_rdata;
                    end
                    state_d   = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            penable_q <= penable_d;
            psel_q    <= psel_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PENABLE = penable_q;
    assign PSEL    = psel_q;
    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign busy    = (state_q != S_IDLE);

endmodule
